shiftreg_driver: RTL and testbench

SHIFTREG_DRIVER -- requirements
Module: shiftreg_driver

---
 rtl/shiftreg_driver.sv | 182 ++++++++++++++++++
 tb/tb_shiftreg_driver.sv | 132 +++++++++++++
 2 files changed

// File: rtl/shiftreg_driver.sv
// shiftreg_driver
//   Serialises a WIDTH-bit parallel word into an external shift-register
//   chain (MSB first), then pulses the chain's latch strobe.
//   Each bit occupies 2*DIV clk cycles: sr_clk is low for the first DIV
//   cycles and high for the next DIV cycles.
//
// Parameters
//   WIDTH   chain length in bits
//   DIV     clk cycles per half-period of sr_clk (1..255)
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   start, din      one-cycle request and the word to send (captured on accept)
//   sr_din, sr_clk  serial data / shift clock to the chain
//   load_sr         latch strobe to the chain (2*DIV cycles after the last bit)
//   busy            high for the whole transfer, (WIDTH+1)*2*DIV cycles
//   done            one-cycle pulse in the first idle cycle after the load
//
// Optional build macro SHIFTREG_READBACK_EN adds:
//   dout_sr         chain output, sampled on the clk edge where sr_clk rises
//   rb_data         word shifted back from the chain, updated at transfer end
//   rb_valid        pulses together with done
module shiftreg_driver #(
  parameter int WIDTH = 170,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             sr_din,
  output logic             sr_clk,
  output logic             load_sr,
  output logic             busy,
`ifdef SHIFTREG_READBACK_EN
  input  logic             dout_sr,
  output logic [WIDTH-1:0] rb_data,
  output logic             rb_valid,
`endif
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [7:0]    DIV_LAST = 8'(DIV - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shadow, shadow_n;
  logic [CW-1:0]    bit_cnt, bit_cnt_n;
  logic [7:0]       div_cnt, div_cnt_n;
  logic             sr_din_n, sr_clk_n, load_sr_n, busy_n, done_n;
  logic [WIDTH-1:0] shadow_sh;

`ifdef SHIFTREG_READBACK_EN
  logic [WIDTH-1:0] rb_shift, rb_shift_n, rb_data_n;
  logic             rb_valid_n;
`endif

  // Next bit to present is always the MSB of the shadow shifted once more.
  assign shadow_sh = shadow << 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shadow  <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      sr_din  <= 1'b0;
      sr_clk  <= 1'b0;
      load_sr <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SHIFTREG_READBACK_EN
      rb_shift <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      shadow  <= shadow_n;
      bit_cnt <= bit_cnt_n;
      div_cnt <= div_cnt_n;
      sr_din  <= sr_din_n;
      sr_clk  <= sr_clk_n;
      load_sr <= load_sr_n;
      busy    <= busy_n;
      done    <= done_n;
`ifdef SHIFTREG_READBACK_EN
      rb_shift <= rb_shift_n;
      rb_data  <= rb_data_n;
      rb_valid <= rb_valid_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    shadow_n  = shadow;
    bit_cnt_n = bit_cnt;
    div_cnt_n = div_cnt;
    sr_din_n  = sr_din;
    sr_clk_n  = sr_clk;
    load_sr_n = load_sr;
    busy_n    = busy;
    done_n    = 1'b0;
`ifdef SHIFTREG_READBACK_EN
    rb_shift_n = rb_shift;
    rb_data_n  = rb_data;
    rb_valid_n = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        sr_din_n  = 1'b0;
        sr_clk_n  = 1'b0;
        load_sr_n = 1'b0;
        busy_n    = 1'b0;
        if (start) begin
          state_n   = SHIFT;
          shadow_n  = din;
          sr_din_n  = din[WIDTH-1];
          busy_n    = 1'b1;
          bit_cnt_n = '0;
          div_cnt_n = '0;
`ifdef SHIFTREG_READBACK_EN
          rb_shift_n = '0;
`endif
        end
      end
      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_n = '0;
          if (!sr_clk) begin
            sr_clk_n = 1'b1;
`ifdef SHIFTREG_READBACK_EN
            rb_shift_n = {rb_shift[WIDTH-2:0], dout_sr};
`endif
          end else begin
            sr_clk_n = 1'b0;
            if (bit_cnt == BIT_LAST) begin
              state_n   = LOAD;
              sr_din_n  = 1'b0;
              load_sr_n = 1'b1;
              bit_cnt_n = '0;
            end else begin
              bit_cnt_n = bit_cnt + CW'(1);
              shadow_n  = shadow_sh;
              sr_din_n  = shadow_sh[WIDTH-1];
            end
          end
        end else begin
          div_cnt_n = div_cnt + 8'd1;
        end
      end
      LOAD: begin
        // bit_cnt LSB marks the second half of the load window.
        if (div_cnt == DIV_LAST) begin
          div_cnt_n = '0;
          if (bit_cnt[0]) begin
            state_n   = IDLE;
            load_sr_n = 1'b0;
            busy_n    = 1'b0;
            done_n    = 1'b1;
            bit_cnt_n = '0;
            shadow_n  = '0;
`ifdef SHIFTREG_READBACK_EN
            rb_data_n  = rb_shift;
            rb_valid_n = 1'b1;
`endif
          end else begin
            bit_cnt_n = CW'(1);
          end
        end else begin
          div_cnt_n = div_cnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_shiftreg_driver.sv
module tb_shiftreg_driver;
  localparam int W     = 8;
  localparam int D     = 2;
  localparam int TOTAL = (W + 1) * 2 * D;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] din;
  logic         sr_din, sr_clk, load_sr, busy, done;
  int           checks = 0, errors = 0;

  always #5 clk = ~clk;

`ifdef SHIFTREG_READBACK_EN
  logic         dout_sr;
  logic [W-1:0] rb_data;
  logic         rb_valid;
  logic [W-1:0] chain = 8'h5A;
  always @(posedge sr_clk) chain <= {chain[W-2:0], sr_din};
  assign dout_sr = chain[W-1];
`endif

  shiftreg_driver #(.WIDTH(W), .DIV(D)) dut (
    .clk(clk), .rst(rst), .start(start), .din(din),
    .sr_din(sr_din), .sr_clk(sr_clk), .load_sr(load_sr), .busy(busy),
`ifdef SHIFTREG_READBACK_EN
    .dout_sr(dout_sr), .rb_data(rb_data), .rb_valid(rb_valid),
`endif
    .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {sr_din, sr_clk, load_sr, busy, done} k cycles after the accepting edge.
  function automatic logic [4:0] exp_vec(input logic [W-1:0] d, input int k);
    if (k < W * 2 * D)
      return {d[W - 1 - k / (2 * D)], (k % (2 * D)) >= D, 1'b0, 1'b1, 1'b0};
    else if (k < TOTAL)
      return 5'b00110;
    else
      return 5'b00001;
  endfunction

  // Caller has start=1 and din=d set ahead of the accepting edge.
  task automatic run(input logic [W-1:0] d, input bit b2b, input logic [W-1:0] dn,
                     input logic [W-1:0] rb_exp);
    @(posedge clk);
    #1 start = 1'b0;
    din = W'($urandom);
    for (int k = 0; k <= TOTAL; k++) begin
      @(negedge clk);
      chk($sformatf("xfer %0h k=%0d", d, k), {sr_din, sr_clk, load_sr, busy, done}, exp_vec(d, k));
`ifdef SHIFTREG_READBACK_EN
      chk($sformatf("rb_valid k=%0d", k), rb_valid, k == TOTAL);
      if (k == TOTAL) chk("rb_data", rb_data, rb_exp);
`else
      if (rb_exp === 'x) chk("rb_exp", 0, 1);
`endif
      if (k == 9)  begin start = 1'b1; din = W'($urandom); end
      if (k == 10) start = 1'b0;
      if (k == TOTAL && b2b) begin start = 1'b1; din = dn; end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("idle", {sr_din, sr_clk, load_sr, busy, done}, 0);
    end
  endtask

  logic [W-1:0] prev, d, dn, r;

  initial begin
    rst = 1'b1; start = 1'b0; din = '0;
    #1 chk("reset", {sr_din, sr_clk, load_sr, busy, done}, 0);
    repeat (2) @(negedge clk);
`ifdef SHIFTREG_READBACK_EN
    chk("reset rb", {rb_data, rb_valid}, 0);
`endif
    // First start on the first edge after reset release; 3C follows in the done cycle.
    rst = 1'b0; start = 1'b1; din = 8'hA5;
    run(8'hA5, 1'b1, 8'h3C, 8'h5A);
    run(8'h3C, 1'b0, 8'h00, 8'hA5);
    idle(3);
    prev = 8'h3C;

    d = W'($urandom);
    for (int i = 0; i < 4; i++) begin
      dn = W'($urandom);
      if (i == 0) begin @(negedge clk); start = 1'b1; din = d; end
      run(d, i < 3, dn, prev);
      prev = d;
      d = dn;
    end
    idle(2);

    // Abort during bit 4: four rising edges have reached the chain.
    r = W'($urandom);
    start = 1'b1; din = r;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (18) @(negedge clk);
    rst = 1'b1;
    #1 chk("abort", {sr_din, sr_clk, load_sr, busy, done}, 0);
`ifdef SHIFTREG_READBACK_EN
    chk("abort rb", {rb_data, rb_valid}, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    idle(TOTAL + 4);
    prev = {prev[3:0], r[W-1:4]};
    start = 1'b1; din = 8'h5A;
    run(8'h5A, 1'b0, 8'h00, prev);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
